// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - control FSM for a multicycle RV32I datapath
//
// Sequences each instruction through fetch / decode / execute / memory /
// writeback states and drives every datapath select and enable.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   op              opcode from IR, stable from DECODE onward
//   branch_cond     branch comparison result (1 = taken)
//   mem_ready       shared memory port completes its access this cycle
//   mem_req         memory access active this cycle
//   pc_write        PC load enable
//   ir_write        IR/OldPC load enable
//   reg_write       register file write enable
//   mem_write       data memory write strobe
//   adr_src         memory address select (0 = PC, 1 = ALUOut)
//   alu_src_a       ALU A select (PC / OldPC / rs1 / zero)
//   alu_src_b       ALU B select (rs2 / ImmExt / constant 4)
//   alu_op          ALU operation class (add / compare / funct-decoded)
//   result_src      result bus select (ALUOut / Data / ALUResult)
//   imm_src         immediate format, decoded from op in every state
//   illegal_op      sticky illegal-opcode trap flag
//   instret         retired instruction count, wraps
//   state           current FSM state (debug)
module multicycle_controller #(
  parameter bit MEM_WAIT     = 1'b1,
  parameter bit ENABLE_UTYPE = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             branch_cond,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_write,
  output logic             adr_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic [2:0]       imm_src,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_JALR     = 4'd11,
    S_UTYPE    = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             ready;

  // Without wait support every access is treated as completing immediately.
  assign ready = MEM_WAIT ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    case (state_q)
      S_FETCH: begin
        // PC+4 goes straight from the ALU to the PC while IR loads.
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = ready;
        pc_write   = ready;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm lands in ALUOut as the branch/jal target.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = ENABLE_UTYPE ? S_UTYPE : S_TRAP;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = ready;
        if (ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut; OldPC+4 is the link value.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = branch_cond;
        state_d   = S_FETCH;
      end
      S_JALR: begin
        // rs1+imm overwrites ALUOut, then JAL reuses the same link/jump path.
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = S_JAL;
      end
      S_UTYPE: begin
        // lui adds the immediate to zero, auipc adds it to OldPC.
        alu_src_a = op[5] ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  always_comb begin
    illegal_d = illegal_q | (state_d == S_TRAP);
    instret_d = instret_q;
    if (state_d == S_FETCH && state_q != S_FETCH) instret_d = instret_q + CNT_W'(1);
  end

  always_comb begin
    case (op)
      OP_LOAD, OP_JALR, OP_ITYPE: imm_src = 3'b000;
      OP_STORE:                   imm_src = 3'b001;
      OP_BRANCH:                  imm_src = 3'b010;
      OP_JAL:                     imm_src = 3'b011;
      OP_LUI, OP_AUIPC:           imm_src = 3'b100;
      default:                    imm_src = 3'b000;
    endcase
  end

  assign illegal_op = illegal_q;
  assign instret    = instret_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] RT    = 7'b0110011;
  localparam logic [6:0] IT    = 7'b0010011;
  localparam logic [6:0] BEQ   = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut: default parameters
  logic        rst_n, bc, rdy;
  logic [6:0]  op;
  logic        mr, pw, iw, rw, mw, ad, il;
  logic [1:0]  aa, ab, ao, rs;
  logic [2:0]  im;
  logic [31:0] ir;
  logic [3:0]  st;

  // dut2: no U-type, 4-bit counter
  logic        rst2_n, bc2, rdy2;
  logic [6:0]  op2;
  logic        mr2, pw2, iw2, rw2, mw2, ad2, il2;
  logic [1:0]  aa2, ab2, ao2, rs2;
  logic [2:0]  im2;
  logic [3:0]  ir2;
  logic [3:0]  st2;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .branch_cond(bc), .mem_ready(rdy),
    .mem_req(mr), .pc_write(pw), .ir_write(iw), .reg_write(rw), .mem_write(mw),
    .adr_src(ad), .alu_src_a(aa), .alu_src_b(ab), .alu_op(ao), .result_src(rs),
    .imm_src(im), .illegal_op(il), .instret(ir), .state(st)
  );

  multicycle_controller #(.MEM_WAIT(1'b1), .ENABLE_UTYPE(1'b0), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst2_n), .op(op2), .branch_cond(bc2), .mem_ready(rdy2),
    .mem_req(mr2), .pc_write(pw2), .ir_write(iw2), .reg_write(rw2), .mem_write(mw2),
    .adr_src(ad2), .alu_src_a(aa2), .alu_src_b(ab2), .alu_op(ao2), .result_src(rs2),
    .imm_src(im2), .illegal_op(il2), .instret(ir2), .state(st2)
  );

  typedef struct {
    int          sel;
    int          id;
    logic [53:0] v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  // Moore select outputs per state: {mem_req, adr_src, alu_src_a, alu_src_b, alu_op, result_src}
  function automatic logic [9:0] mux_of(input logic [3:0] s, input logic op5);
    case (s)
      4'd0:    return 10'b1_0_00_10_00_10;
      4'd1:    return 10'b0_0_01_01_00_00;
      4'd2:    return 10'b0_0_10_01_00_00;
      4'd3:    return 10'b1_1_00_00_00_00;
      4'd4:    return 10'b0_0_00_00_00_01;
      4'd5:    return 10'b1_1_00_00_00_00;
      4'd6:    return 10'b0_0_10_00_10_00;
      4'd7:    return 10'b0_0_00_00_00_00;
      4'd8:    return 10'b0_0_10_01_10_00;
      4'd9:    return 10'b0_0_01_10_00_00;
      4'd10:   return 10'b0_0_10_00_01_00;
      4'd11:   return 10'b0_0_10_01_00_00;
      4'd12:   return op5 ? 10'b0_0_11_01_00_00 : 10'b0_0_01_01_00_00;
      default: return 10'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      LW, JALR, IT: return 3'b000;
      SW:           return 3'b001;
      BEQ:          return 3'b010;
      JAL:          return 3'b011;
      LUI, AUIPC:   return 3'b100;
      default:      return 3'b000;
    endcase
  endfunction

  // One cycle of stimulus plus the response expected in that same cycle.
  task automatic cyc(input int sel, input logic r_n, input logic [6:0] o, input logic b,
                     input logic r, input logic [3:0] s, input logic e_iw, input logic e_pw,
                     input logic e_rw, input logic e_mw, input int n, input logic e_il);
    exp_t e;
    @(posedge clk);
    #1;
    if (sel == 0) begin
      rst_n = r_n; op = o; bc = b; rdy = r;
    end else begin
      rst2_n = r_n; op2 = o; bc2 = b; rdy2 = r;
    end
    e.sel = sel;
    e.id  = vec_id;
    e.v   = {s, e_iw, e_pw, e_rw, e_mw, mux_of(s, o[5]), imm_of(o), e_il, 32'(n)};
    q.push_back(e);
    vec_id++;
  endtask

  task automatic fe(input int sel, input logic [6:0] o, input int n);
    cyc(sel, 1'b1, o, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, n, 1'b0);
  endtask

  task automatic sp(input int sel, input logic [6:0] o, input logic b, input logic [3:0] s,
                    input logic e_pw, input logic e_rw, input logic e_mw, input int n);
    cyc(sel, 1'b1, o, b, 1'b1, s, 1'b0, e_pw, e_rw, e_mw, n, 1'b0);
  endtask

  // Monitor: compares every presented cycle against the scoreboard head.
  initial begin
    exp_t        e;
    logic [53:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel == 0)
          act = {st, iw, pw, rw, mw, mr, ad, aa, ab, ao, rs, im, il, ir};
        else
          act = {st2, iw2, pw2, rw2, mw2, mr2, ad2, aa2, ab2, ao2, rs2, im2, il2, 28'd0, ir2};
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL vec%0d dut%0d: got %h expected %h", e.id, e.sel + 1, act, e.v);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; op = LW; bc = 1'b0; rdy = 1'b1;
    rst2_n = 1'b0; op2 = RT; bc2 = 1'b0; rdy2 = 1'b1;

    // reset state
    cyc(0, 1'b0, LW, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc(0, 1'b0, LW, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);

    // lw, no waits: 0,1,2,3,4
    fe(0, LW, 0);
    sp(0, LW, 1'b0, 4'd1, 0, 0, 0, 0);
    sp(0, LW, 1'b0, 4'd2, 0, 0, 0, 0);
    sp(0, LW, 1'b0, 4'd3, 0, 0, 0, 0);
    sp(0, LW, 1'b0, 4'd4, 0, 1, 0, 0);

    // partial lw stalled in MEMREAD, then async reset drops it
    fe(0, LW, 1);
    sp(0, LW, 1'b0, 4'd1, 0, 0, 0, 1);
    sp(0, LW, 1'b0, 4'd2, 0, 0, 0, 1);
    cyc(0, 1'b1, LW, 1'b0, 1'b0, 4'd3, 0, 0, 0, 0, 1, 1'b0);
    cyc(0, 1'b0, LW, 1'b0, 1'b1, 4'd0, 1, 1, 0, 0, 0, 1'b0);

    // sw with a fetch wait and three MEMWRITE wait cycles
    cyc(0, 1'b1, SW, 1'b0, 1'b0, 4'd0, 0, 0, 0, 0, 0, 1'b0);
    fe(0, SW, 0);
    sp(0, SW, 1'b0, 4'd1, 0, 0, 0, 0);
    sp(0, SW, 1'b0, 4'd2, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc(0, 1'b1, SW, 1'b0, 1'b0, 4'd5, 0, 0, 0, 0, 0, 1'b0);
    cyc(0, 1'b1, SW, 1'b0, 1'b1, 4'd5, 0, 0, 0, 1, 0, 1'b0);

    // beq taken, then not taken
    fe(0, BEQ, 1);
    sp(0, BEQ, 1'b1, 4'd1, 0, 0, 0, 1);
    sp(0, BEQ, 1'b1, 4'd10, 1, 0, 0, 1);
    fe(0, BEQ, 2);
    sp(0, BEQ, 1'b0, 4'd1, 0, 0, 0, 2);
    sp(0, BEQ, 1'b0, 4'd10, 0, 0, 0, 2);

    // jalr: 0,1,11,9,7
    fe(0, JALR, 3);
    sp(0, JALR, 1'b0, 4'd1, 0, 0, 0, 3);
    sp(0, JALR, 1'b0, 4'd11, 0, 0, 0, 3);
    sp(0, JALR, 1'b0, 4'd9, 1, 0, 0, 3);
    sp(0, JALR, 1'b0, 4'd7, 0, 1, 0, 3);

    // R-type, I-type, jal, lui, auipc
    fe(0, RT, 4);
    sp(0, RT, 1'b0, 4'd1, 0, 0, 0, 4);
    sp(0, RT, 1'b0, 4'd6, 0, 0, 0, 4);
    sp(0, RT, 1'b0, 4'd7, 0, 1, 0, 4);
    fe(0, IT, 5);
    sp(0, IT, 1'b0, 4'd1, 0, 0, 0, 5);
    sp(0, IT, 1'b0, 4'd8, 0, 0, 0, 5);
    sp(0, IT, 1'b0, 4'd7, 0, 1, 0, 5);
    fe(0, JAL, 6);
    sp(0, JAL, 1'b0, 4'd1, 0, 0, 0, 6);
    sp(0, JAL, 1'b0, 4'd9, 1, 0, 0, 6);
    sp(0, JAL, 1'b0, 4'd7, 0, 1, 0, 6);
    fe(0, LUI, 7);
    sp(0, LUI, 1'b0, 4'd1, 0, 0, 0, 7);
    sp(0, LUI, 1'b0, 4'd12, 0, 0, 0, 7);
    sp(0, LUI, 1'b0, 4'd7, 0, 1, 0, 7);
    fe(0, AUIPC, 8);
    sp(0, AUIPC, 1'b0, 4'd1, 0, 0, 0, 8);
    sp(0, AUIPC, 1'b0, 4'd12, 0, 0, 0, 8);
    sp(0, AUIPC, 1'b0, 4'd7, 0, 1, 0, 8);

    // undefined opcode traps, flag sticky, no retire
    fe(0, 7'b0000000, 9);
    sp(0, 7'b0000000, 1'b0, 4'd1, 0, 0, 0, 9);
    for (int i = 0; i < 3; i++)
      cyc(0, 1'b1, 7'b0000000, 1'b0, 1'b1, 4'd13, 0, 0, 0, 0, 9, 1'b1);

    // dut2: 16 R-type instructions wrap the 4-bit counter
    for (int k = 0; k < 16; k++) begin
      fe(1, RT, k);
      sp(1, RT, 1'b0, 4'd1, 0, 0, 0, k);
      sp(1, RT, 1'b0, 4'd6, 0, 0, 0, k);
      sp(1, RT, 1'b0, 4'd7, 0, 1, 0, k);
    end
    // lui is illegal without U-type support
    fe(1, LUI, 0);
    sp(1, LUI, 1'b0, 4'd1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++)
      cyc(1, 1'b1, LUI, 1'b0, 1'b1, 4'd13, 0, 0, 0, 0, 0, 1'b1);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
